// File: rtl/adc_trig_capture.sv
// adc_trig_capture: hysteresis trigger and pre/post-trigger capture sequencer for a circular sample RAM
module adc_trig_capture #(
    parameter int DW      = 8,
    parameter int DEPTH   = 1024,
    parameter int AW      = $clog2(DEPTH),
    parameter int AUTO_TO = 65535
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data,
    input  logic          data_valid,
    input  logic [DW-1:0] level_hi,
    input  logic [DW-1:0] level_lo,
    input  logic [1:0]    edge_mode,
    input  logic [AW-1:0] pre_len,
    input  logic          auto_en,
    input  logic          arm,
    input  logic          force_trig,
    output logic          level,
    output logic          trig_pulse,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [AW-1:0] trig_addr,
    output logic          trig_auto,
    output logic          busy,
    output logic          done
);
    localparam int CW = $clog2(AUTO_TO + 1);
    localparam logic [AW:0] ONE = 1;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    state;
    logic [AW-1:0] ptr, pre_cnt, post_cnt, p, post_len;
    logic [CW-1:0] auto_cnt;
    logic          force_pend;
    logic          level_next, edge_ev, pre_last, post_last, auto_sat, auto_hit, trig;

    // pre_len is AW bits wide, so it can never exceed DEPTH-1
    assign p         = pre_len;
    assign post_len  = AW'(DEPTH - 1) - p;
    assign busy      = state == S_PRE || state == S_WAIT || state == S_POST;
    assign done      = state == S_DONE;
    assign pre_last  = {1'b0, pre_cnt} + ONE >= {1'b0, p};
    assign post_last = {1'b0, post_cnt} + ONE >= {1'b0, post_len};
    assign auto_sat  = auto_cnt == CW'(AUTO_TO - 1);
    assign auto_hit  = auto_en && auto_sat;

    // hysteresis compare with the high threshold taking priority, and the selected edge
    always_comb begin
        level_next = data > level_hi ? 1'b1 : data < level_lo ? 1'b0 : level;
        edge_ev    = edge_mode == 2'b00 ? (!level && level_next) :
                     edge_mode == 2'b01 ? (level && !level_next) :
                     edge_mode == 2'b10 ? (level != level_next) : 1'b0;
        trig       = state == S_WAIT && data_valid && (edge_ev || force_pend || force_trig || auto_hit);
    end

    // comparator state and edge pulse, running in every sequencer state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level      <= 1'b0;
            trig_pulse <= 1'b0;
        end else begin
            trig_pulse <= data_valid && edge_ev;
            if (data_valid) level <= level_next;
        end
    end

    // capture sequencer and buffer write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            auto_cnt   <= '0;
            force_pend <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            trig_addr  <= '0;
            trig_auto  <= 1'b0;
        end else begin
            wr_en      <= busy && data_valid;
            force_pend <= state == S_WAIT && !trig && (force_pend || force_trig);
            if (busy && data_valid) begin
                wr_addr <= ptr;
                wr_data <= data;
                ptr     <= ptr + AW'(1);
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state    <= p == '0 ? S_WAIT : S_PRE;
                        pre_cnt  <= '0;
                        auto_cnt <= '0;
                    end
                end
                S_PRE: begin
                    if (data_valid) begin
                        pre_cnt <= pre_cnt + AW'(1);
                        if (pre_last) begin
                            state    <= S_WAIT;
                            auto_cnt <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (trig) begin
                        trig_addr <= ptr;
                        trig_auto <= !edge_ev;
                        post_cnt  <= '0;
                        state     <= post_len == '0 ? S_DONE : S_POST;
                    end else if (data_valid && !auto_sat) begin
                        auto_cnt <= auto_cnt + CW'(1);
                    end
                end
                S_POST: begin
                    if (data_valid) begin
                        post_cnt <= post_cnt + AW'(1);
                        if (post_last) state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_trig_capture.sv
// tb_adc_trig_capture: directed stimulus against a sample-count model of the capture window
module tb_adc_trig_capture;
    localparam int DW = 8, DEPTH = 16, AW = 4, AUTO_TO = 5;

    logic          clk = 1'b0, rst = 1'b1;
    logic [DW-1:0] data = '0, level_hi = 8'd200, level_lo = 8'd180;
    logic          data_valid = 1'b0, auto_en = 1'b0, arm = 1'b0, force_trig = 1'b0;
    logic [1:0]    edge_mode = 2'b00;
    logic [AW-1:0] pre_len = '0;
    logic          level, trig_pulse, wr_en, trig_auto, busy, done;
    logic [AW-1:0] wr_addr, trig_addr;
    logic [DW-1:0] wr_data;

    int n_cmp = 0, n_bad = 0, nw;

    // model: writes since arm, index of the trigger sample, and the persistent pointer
    logic m_level = 0, m_pulse = 0, m_wr_en = 0, m_busy = 0, m_done = 0, m_trig_auto = 0, m_fp = 0;
    int   m_wr_addr = 0, m_wr_data = 0, m_trig_addr = 0, m_ptr = 0, m_wcnt = 0, m_tidx = -1;
    int   p;
    logic nl, ev, in_wait;

    adc_trig_capture #(.DW(DW), .DEPTH(DEPTH), .AUTO_TO(AUTO_TO)) dut (
        .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
        .level_hi(level_hi), .level_lo(level_lo), .edge_mode(edge_mode),
        .pre_len(pre_len), .auto_en(auto_en), .arm(arm), .force_trig(force_trig),
        .level(level), .trig_pulse(trig_pulse), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .trig_addr(trig_addr), .trig_auto(trig_auto),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic put(input logic v, input logic [DW-1:0] d);
        data_valid = v;
        data = d;
        @(negedge clk);
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_level = 0; m_pulse = 0; m_wr_en = 0; m_busy = 0; m_done = 0; m_trig_auto = 0;
            m_fp = 0; m_wr_addr = 0; m_wr_data = 0; m_trig_addr = 0; m_ptr = 0; m_wcnt = 0; m_tidx = -1;
        end else begin
            p  = int'(pre_len);
            nl = data > level_hi ? 1'b1 : data < level_lo ? 1'b0 : m_level;
            ev = data_valid && (edge_mode == 2'b00 ? (!m_level && nl) : edge_mode == 2'b01 ? (m_level && !nl) :
                                edge_mode == 2'b10 ? (m_level != nl) : 1'b0);
            m_pulse = ev;
            m_wr_en = 0;
            if (!m_busy) begin
                if (arm) begin
                    m_busy = 1; m_done = 0; m_wcnt = 0; m_tidx = -1; m_fp = 0;
                end
            end else begin
                in_wait = m_tidx < 0 && m_wcnt >= p;
                if (in_wait && force_trig) m_fp = 1;
                if (data_valid) begin
                    m_wr_en = 1; m_wr_addr = m_ptr; m_wr_data = int'(data);
                    if (in_wait && (ev || m_fp || (auto_en && m_wcnt - p >= AUTO_TO - 1))) begin
                        m_tidx = m_wcnt; m_trig_addr = m_ptr; m_trig_auto = !ev; m_fp = 0;
                    end
                    m_ptr = (m_ptr + 1) % DEPTH;
                    m_wcnt++;
                    if (m_tidx >= 0 && m_wcnt == m_tidx + DEPTH - p) begin
                        m_busy = 0; m_done = 1;
                    end
                end
            end
            if (data_valid) m_level = nl;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("level", level, m_level);
            chk("trig_pulse", trig_pulse, m_pulse);
            chk("wr_en", wr_en, m_wr_en);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("trig_addr", trig_addr, m_trig_addr);
            chk("trig_auto", trig_auto, m_trig_auto);
            if (m_wr_en) begin
                chk("wr_addr", wr_addr, m_wr_addr);
                chk("wr_data", wr_data, m_wr_data);
            end
        end
    end

    initial begin
        automatic logic [DW-1:0] hv[6] = '{8'd170, 8'd190, 8'd210, 8'd190, 8'd175, 8'd210};
        automatic logic          hl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        automatic logic          hp[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);

        put(1'b1, 8'd190);
        chk("mid_band_level", level, 0);
        chk("mid_band_pulse", trig_pulse, 0);
        for (int i = 0; i < 6; i++) begin
            put(1'b1, hv[i]);
            chk("hyst_level", level, hl[i]);
            chk("hyst_pulse", trig_pulse, hp[i]);
        end
        put(1'b1, 8'd50);
        chk("low_level", level, 0);
        level_hi = 8'd100;
        level_lo = 8'd150;
        put(1'b1, 8'd120);
        chk("hi_priority_level", level, 1);

        level_hi = 8'd200;
        level_lo = 8'd180;
        put(1'b1, 8'd100);
        pre_len = 4'd4;
        arm = 1'b1;
        put(1'b0, 8'd0);
        arm = 1'b0;
        chk("arm_busy", busy, 1);
        nw = 0;
        for (int i = 0; i < 22; i++) begin
            put(1'b1, (20 * i + 1) > 255 ? 8'd255 : 8'(20 * i + 1));
            if (wr_en) nw++;
            if (i == 20) chk("post_not_done", done, 0);
        end
        chk("ramp_writes", nw, 22);
        chk("ramp_trig_addr", trig_addr, 10);
        chk("ramp_trig_auto", trig_auto, 0);
        chk("ramp_done", done, 1);
        chk("ramp_last_addr", wr_addr, 5);
        put(1'b1, 8'd255);
        chk("done_no_write", wr_en, 0);

        edge_mode = 2'b11;
        auto_en = 1'b1;
        pre_len = 4'd0;
        arm = 1'b1;
        put(1'b0, 8'd0);
        arm = 1'b0;
        nw = 0;
        for (int i = 0; i < 20; i++) begin
            put(1'b1, 8'(50 + i));
            if (wr_en) nw++;
            if (i == 3) chk("auto_not_yet", busy && trig_addr == 10 && trig_auto, 0);
            if (i == 4) begin
                chk("auto_trig_auto", trig_auto, 1);
                chk("auto_trig_addr", trig_addr, 10);
            end
        end
        chk("auto_writes", nw, 20);
        chk("auto_done", done, 1);

        edge_mode = 2'b00;
        auto_en = 1'b0;
        arm = 1'b1;
        put(1'b0, 8'd0);
        arm = 1'b0;
        put(1'b1, 8'd100);
        put(1'b1, 8'd100);
        force_trig = 1'b1;
        put(1'b1, 8'd210);
        force_trig = 1'b0;
        chk("force_edge_trig_auto", trig_auto, 0);
        chk("force_edge_trig_addr", trig_addr, 12);
        repeat (15) put(1'b1, 8'd100);
        chk("force_edge_done", done, 1);

        arm = 1'b1;
        put(1'b0, 8'd0);
        arm = 1'b0;
        put(1'b1, 8'd100);
        put(1'b1, 8'd100);
        force_trig = 1'b1;
        put(1'b0, 8'd0);
        force_trig = 1'b0;
        put(1'b0, 8'd0);
        put(1'b0, 8'd0);
        chk("force_stall_addr", trig_addr, 12);
        put(1'b1, 8'd100);
        chk("force_stall_trig_auto", trig_auto, 1);
        chk("force_stall_trig_addr", trig_addr, 14);

        repeat (3) put(1'b1, 8'd250);
        chk("pre_rst_level", level, 1);
        chk("pre_rst_wr_addr", wr_addr, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        chk("async_wr_en", wr_en, 0);
        chk("async_wr_addr", wr_addr, 0);
        chk("async_level", level, 0);
        @(negedge clk);
        rst = 1'b0;
        pre_len = 4'd2;
        arm = 1'b1;
        put(1'b0, 8'd0);
        arm = 1'b0;
        chk("rearm_busy", busy, 1);
        put(1'b1, 8'd30);
        chk("rearm_wr_en", wr_en, 1);
        chk("rearm_wr_addr", wr_addr, 0);
        put(1'b1, 8'd40);
        chk("rearm_wr_addr2", wr_addr, 1);
        put(1'b1, 8'd50);
        chk("rearm_still_busy", busy, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
